// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver: bit/frame state
// encodings, frame header value and the running checksum helper.
package uart_pkg;

  typedef enum logic [2:0] {
    BIT_IDLE   = 3'd0,
    BIT_START  = 3'd1,
    BIT_DATA   = 3'd2,
    BIT_STOP   = 3'd3,
    BIT_WAITHI = 3'd4
  } bit_state_e;

  typedef enum logic [1:0] {
    FRM_HDR = 2'd0,
    FRM_PAY = 2'd1,
    FRM_CHK = 2'd2
  } frame_state_e;

  localparam logic [7:0] FRAME_HDR     = 8'hA5;
  localparam int         PAYLOAD_BYTES = 4;

  // Frame checksum is a plain XOR over the payload bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Serial input, error-clear control and received byte/word outputs of the
// framed UART receiver.
interface uart_frame_rx_if;
  logic        rx_pin_in;
  logic        clr_err;
  logic [7:0]  rx_data;
  logic        byte_valid;
  logic [31:0] rx_word;
  logic        word_valid;
  logic        frame_err;
  logic        chk_err;

  modport slave (
    input  rx_pin_in, clr_err,
    output rx_data, byte_valid, rx_word, word_valid, frame_err, chk_err
  );

  modport master (
    output rx_pin_in, clr_err,
    input  rx_data, byte_valid, rx_word, word_valid, frame_err, chk_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the line, centres on the start bit and
// samples each bit mid-cell; reports good bytes and bad-stop events as pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin_in,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_evt
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ST_IDLE   = BIT_IDLE;
  localparam logic [2:0] ST_START  = BIT_START;
  localparam logic [2:0] ST_DATA   = BIT_DATA;
  localparam logic [2:0] ST_STOP   = BIT_STOP;
  localparam logic [2:0] ST_WAITHI = BIT_WAITHI;

  logic             sync1_r;
  logic             sync2_r;
  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       data_r;
  logic             valid_r;
  logic             ferr_r;

  // Line synchronizer, bit FSM, baud counter and byte output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      sync1_r <= rx_pin_in;
      sync2_r <= sync1_r;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!sync2_r) state_r <= ST_START;
          else          state_r <= ST_IDLE;
        end
        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            state_r   <= sync2_r ? ST_IDLE : ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= CNT_ZERO;
            shift_r   <= {sync2_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) state_r <= ST_STOP;
            else                   state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
            if (sync2_r) begin
              data_r  <= shift_r;
              valid_r <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              ferr_r  <= 1'b1;
              state_r <= ST_WAITHI;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAITHI: begin
          // A held-low break must not be mistaken for a new start bit.
          cnt_r <= CNT_ZERO;
          if (sync2_r) state_r <= ST_IDLE;
          else         state_r <= ST_WAITHI;
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data    = data_r;
  assign byte_valid = valid_r;
  assign frame_evt  = ferr_r;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: header 8'hA5, four payload bytes (LSB byte first) and
// an XOR check byte; good frames update rx_word, errors raise sticky flags.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic            CLK100MHZ,
  input  logic            rst_n,
  uart_frame_rx_if.slave  bus
);

  localparam logic [1:0] FS_HDR   = FRM_HDR;
  localparam logic [1:0] FS_PAY   = FRM_PAY;
  localparam logic [1:0] FS_CHK   = FRM_CHK;
  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_BYTES - 1);

  logic [7:0]  byte_data_s;
  logic        byte_valid_s;
  logic        frame_evt_s;
  logic        chk_evt_s;

  logic [1:0]  fstate_r;
  logic [1:0]  idx_r;
  logic [7:0]  acc_r;
  logic [31:0] payload_r;
  logic [31:0] rx_word_r;
  logic        word_valid_r;
  logic        frame_err_r;
  logic        chk_err_r;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (CLK100MHZ),
    .rst_n      (rst_n),
    .rx_pin_in  (bus.rx_pin_in),
    .rx_data    (byte_data_s),
    .byte_valid (byte_valid_s),
    .frame_evt  (frame_evt_s)
  );

  // Check byte arriving with a value different from the running XOR.
  always_comb begin
    chk_evt_s = 1'b0;
    if (byte_valid_s && (fstate_r == FS_CHK) && (byte_data_s != acc_r)) chk_evt_s = 1'b1;
    else                                                                chk_evt_s = 1'b0;
  end

  // Frame FSM: collect payload, verify checksum, publish the word.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      fstate_r     <= FS_HDR;
      idx_r        <= 2'd0;
      acc_r        <= 8'h00;
      payload_r    <= 32'h0000_0000;
      rx_word_r    <= 32'h0000_0000;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      case (fstate_r)
        FS_HDR: begin
          if (byte_valid_s && (byte_data_s == FRAME_HDR)) begin
            fstate_r <= FS_PAY;
            idx_r    <= 2'd0;
            acc_r    <= 8'h00;
          end else begin
            fstate_r <= FS_HDR;
          end
        end
        FS_PAY: begin
          // A header value here is just payload; no resynchronisation.
          if (frame_evt_s) begin
            fstate_r <= FS_HDR;
          end else if (byte_valid_s) begin
            payload_r[{idx_r, 3'b000} +: 8] <= byte_data_s;
            acc_r <= chk_update(acc_r, byte_data_s);
            if (idx_r == LAST_IDX) fstate_r <= FS_CHK;
            else                   idx_r    <= idx_r + 2'd1;
          end
        end
        FS_CHK: begin
          if (frame_evt_s) begin
            fstate_r <= FS_HDR;
          end else if (byte_valid_s) begin
            if (byte_data_s == acc_r) begin
              rx_word_r    <= payload_r;
              word_valid_r <= 1'b1;
            end
            fstate_r <= FS_HDR;
          end
        end
        default: fstate_r <= FS_HDR;
      endcase
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      chk_err_r   <= 1'b0;
    end else begin
      if (frame_evt_s)      frame_err_r <= 1'b1;
      else if (bus.clr_err) frame_err_r <= 1'b0;
      if (chk_evt_s)        chk_err_r   <= 1'b1;
      else if (bus.clr_err) chk_err_r   <= 1'b0;
    end
  end

  assign bus.rx_data    = byte_data_s;
  assign bus.byte_valid = byte_valid_s;
  assign bus.rx_word    = rx_word_r;
  assign bus.word_valid = word_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.chk_err    = chk_err_r;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed scenarios plus random frames,
// compared against a byte-stream model of the framing and checksum rules.
module tb_uart_frame_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_rx_if bus();

  uart_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int bv_lat = 0;
  int last_bv_cyc = -10;
  int lat_bad = 0;

  logic [7:0]  got_bytes[$];
  logic [31:0] got_words[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  logic [7:0]  fbuf[$];
  logic [7:0]  exp_last_byte;
  logic [31:0] exp_last_word;
  logic        exp_ferr;
  logic        exp_chk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output pulse and the timing between byte and word pulses.
  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) begin
      got_bytes.push_back(bus.rx_data);
      last_bv_cyc = cyc;
      bv_lat = cyc - start_cyc;
    end
    if (bus.word_valid === 1'b1) begin
      got_words.push_back(bus.rx_word);
      if (cyc != last_bv_cyc + 1) lat_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is A5 followed by five bytes; word valid when
  // the last equals the XOR of the four before it.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    exp_bytes.push_back(b);
    exp_last_byte = b;
    if (fbuf.size() == 0) begin
      if (b == 8'hA5) fbuf.push_back(b);
    end else begin
      fbuf.push_back(b);
      if (fbuf.size() == 6) begin
        x = fbuf[1] ^ fbuf[2] ^ fbuf[3] ^ fbuf[4];
        if (x == fbuf[5]) begin
          exp_last_word = {fbuf[4], fbuf[3], fbuf[2], fbuf[1]};
          exp_words.push_back(exp_last_word);
        end else begin
          exp_chk = 1'b1;
        end
        fbuf.delete();
      end
    end
  endtask

  task automatic model_ferr();
    exp_ferr = 1'b1;
    fbuf.delete();
  endtask

  task automatic model_reset();
    fbuf.delete();
    exp_last_byte = 8'h00;
    exp_last_word = 32'h0;
    exp_ferr = 1'b0;
    exp_chk = 1'b0;
  endtask

  task automatic bit_wait();
    repeat (CPB) @(posedge clk);
  endtask

  // low_stop = 0 sends a proper stop bit; otherwise the stop bit is held low for that many bit times.
  task automatic send_byte(input logic [7:0] b, input int low_stop);
    @(posedge clk);
    bus.rx_pin_in = 1'b0;
    start_cyc = cyc;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      bus.rx_pin_in = b[i];
      bit_wait();
    end
    if (low_stop == 0) begin
      bus.rx_pin_in = 1'b1;
      bit_wait();
    end else begin
      bus.rx_pin_in = 1'b0;
      repeat (low_stop) bit_wait();
      bus.rx_pin_in = 1'b1;
      bit_wait();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic send_model(input logic [7:0] b);
    send_byte(b, 0);
    model_byte(b);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    bus.clr_err = 1'b1;
    @(posedge clk);
    bus.clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_chk = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s_nbytes", tag), 32'(got_bytes.size()), 32'(exp_bytes.size()));
    while (got_bytes.size() > 0 && exp_bytes.size() > 0)
      check($sformatf("%s_byte", tag), 32'(got_bytes.pop_front()), 32'(exp_bytes.pop_front()));
    check($sformatf("%s_nwords", tag), 32'(got_words.size()), 32'(exp_words.size()));
    while (got_words.size() > 0 && exp_words.size() > 0)
      check($sformatf("%s_word", tag), got_words.pop_front(), exp_words.pop_front());
    got_bytes.delete(); exp_bytes.delete();
    got_words.delete(); exp_words.delete();
    check($sformatf("%s_rx_data", tag), 32'(bus.rx_data), 32'(exp_last_byte));
    check($sformatf("%s_rx_word", tag), bus.rx_word, exp_last_word);
    check($sformatf("%s_frame_err", tag), 32'(bus.frame_err), 32'(exp_ferr));
    check($sformatf("%s_chk_err", tag), 32'(bus.chk_err), 32'(exp_chk));
  endtask

  task automatic check_zero(input string tag);
    check($sformatf("%s_rx_data", tag), 32'(bus.rx_data), 32'h0);
    check($sformatf("%s_rx_word", tag), bus.rx_word, 32'h0);
    check($sformatf("%s_byte_valid", tag), 32'(bus.byte_valid), 32'h0);
    check($sformatf("%s_word_valid", tag), 32'(bus.word_valid), 32'h0);
    check($sformatf("%s_frame_err", tag), 32'(bus.frame_err), 32'h0);
    check($sformatf("%s_chk_err", tag), 32'(bus.chk_err), 32'h0);
  endtask

  initial begin
    logic [7:0] p [4];
    logic [7:0] c;
    logic [7:0] b;
    int kind;
    int k;
    logic [7:0] f1 [6];
    logic [7:0] f2 [6];

    bus.rx_pin_in = 1'b1;
    bus.clr_err = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check_all("post_reset");

    // Single byte, including its position relative to the start edge.
    send_model(8'h3C);
    check("byte_latency_ok", 32'((bv_lat >= 150 && bv_lat <= 160) ? 1 : 0), 32'h1);
    check_all("byte_3c");

    // Bad checksum, then a good frame.
    f1 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    foreach (f1[i]) send_model(f1[i]);
    check_all("bad_chk");
    f2 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    foreach (f2[i]) send_model(f2[i]);
    check_all("good_frame");

    // Short low glitch on an idle line.
    pulse_clr();
    @(posedge clk);
    bus.rx_pin_in = 1'b0;
    repeat (4) @(posedge clk);
    bus.rx_pin_in = 1'b1;
    repeat (40) @(posedge clk);
    check_all("glitch");
    send_model(8'h5A);
    check_all("after_glitch");

    // Stop bit held low for three bit times, recovery and clear.
    send_byte(8'hFF, 3);
    model_ferr();
    check_all("break");
    send_model(8'h01);
    check_all("after_break");
    pulse_clr();
    check_all("clr_err");

    // Reset during the fourth byte of a frame.
    send_model(8'hA5);
    send_model(8'h11);
    send_model(8'h22);
    check_all("pre_reset");
    @(posedge clk);
    bus.rx_pin_in = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    model_reset();
    bus.rx_pin_in = 1'b1;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    f1 = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    foreach (f1[i]) send_model(f1[i]);
    check_all("after_reset");

    // Framing error inside the payload, then a good frame.
    send_model(8'hA5);
    send_model(8'h11);
    send_byte(8'h22, 1);
    model_ferr();
    f2 = '{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    foreach (f2[i]) send_model(f2[i]);
    check_all("ferr_payload");

    // Random traffic.
    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(0, 4);
      for (int j = 0; j < 4; j++) p[j] = 8'($urandom);
      if (kind == 3) p[$urandom_range(0, 3)] = 8'hA5;
      c = p[0] ^ p[1] ^ p[2] ^ p[3];
      case (kind)
        0, 3: begin
          send_model(8'hA5);
          for (int j = 0; j < 4; j++) send_model(p[j]);
          send_model(c);
        end
        1: begin
          send_model(8'hA5);
          for (int j = 0; j < 4; j++) send_model(p[j]);
          send_model(c ^ 8'($urandom_range(1, 255)));
        end
        2: begin
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h00;
          send_model(b);
        end
        default: begin
          k = $urandom_range(0, 3);
          send_model(8'hA5);
          for (int j = 0; j < k; j++) send_model(p[j]);
          send_byte(8'($urandom), $urandom_range(1, 2));
          model_ferr();
        end
      endcase
      check_all($sformatf("rand%0d", it));
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check_all($sformatf("rand_clr%0d", it));
      end
    end

    check("word_latency", 32'(lat_bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default CLK_FREQ/BAUD (868), meaning the clock cycles per bit; it SHALL be overridable for simulation.
REQ-004 The block SHALL have port CLK100MHZ, input, width 1: the single clock; all logic SHALL run on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port rx_pin_in, input, width 1: the serial line, 8N1 format, idle high, LSB first.
REQ-007 The block SHALL have port clr_err, input, width 1: synchronous clear of the sticky error flags.
REQ-008 The block SHALL have port rx_data, output, width 8: the last good received byte.
REQ-009 The block SHALL have port byte_valid, output, width 1: a one-cycle pulse when rx_data updates.
REQ-010 The block SHALL have port rx_word, output, width 32: the last good frame payload.
REQ-011 The block SHALL have port word_valid, output, width 1: a one-cycle pulse when rx_word updates.
REQ-012 The block SHALL have port frame_err, output, width 1: sticky flag for a bad stop bit.
REQ-013 The block SHALL have port chk_err, output, width 1: sticky flag for a frame checksum mismatch.

Function
REQ-014 rx_pin_in SHALL pass through a 2-FF synchronizer, and all decisions SHALL use the synchronized value.
REQ-015 The bit FSM SHALL use states IDLE, START, DATA, STOP and WAITHI.
- IDLE->START on a synchronized low.
REQ-016 In START, after CLKS_PER_BIT/2 cycles the line SHALL be resampled.
- Low -> DATA with the bit counter cleared.
- High -> IDLE (glitch rejected; no flags set).
REQ-017 In DATA, the line SHALL be sampled every CLKS_PER_BIT cycles, 8 samples total, shifted LSB first.
- After the 8th sample -> STOP.
REQ-018 In STOP, the line SHALL be sampled after CLKS_PER_BIT cycles.
- High: rx_data SHALL load the byte and byte_valid SHALL pulse on the next cycle; then -> IDLE.
- Low: frame_err SHALL be set, there SHALL be no byte_valid, and the FSM -> WAITHI.
REQ-019 WAITHI SHALL remain until the synchronized line is high, then -> IDLE (no false start on a break).
REQ-020 The baud counter SHALL be wide enough for CLKS_PER_BIT-1, SHALL count 0..CLKS_PER_BIT-1, and SHALL reload to 0 on every sample.
REQ-021 The frame FSM SHALL use states HDR, PAY and CHK, and SHALL advance only on byte_valid.
REQ-022 In HDR, 8'hA5 -> PAY with the index at 0 and the XOR accumulator at 0; any other byte SHALL be discarded.
REQ-023 In PAY, byte n (n=0..3) SHALL be stored at payload bits [8n+7:8n] and XORed into the accumulator.
- After n=3 -> CHK.
REQ-024 In CHK, a byte equal to the accumulator SHALL load rx_word and pulse word_valid exactly one cycle after that byte's byte_valid.
- Mismatch SHALL set chk_err and leave rx_word unchanged.
- Either way -> HDR.
REQ-025 A frame_err event while in PAY or CHK SHALL return the frame FSM to HDR and discard the partial payload.
REQ-026 A byte of 8'hA5 inside PAY SHALL be treated as payload (no resync).
REQ-027 clr_err SHALL clear both sticky flags.
- If an error event occurs in the same cycle as clr_err, the set SHALL win.
REQ-028 Sticky flags SHALL otherwise hold until reset.
REQ-029 Latency SHALL be as follows:
- byte_valid 1 cycle after the stop-bit sample.
- word_valid 1 cycle after the check byte's byte_valid.

Reset
REQ-030 On rst_n low, all of the following SHALL clear asynchronously:
- rx_data=0, rx_word=0, byte_valid=0, word_valid=0, frame_err=0, chk_err=0.
- Bit FSM=IDLE, frame FSM=HDR, counters=0.
- Synchronizer flops=1 (idle line).
REQ-031 Reset asserted mid-byte or mid-frame SHALL abandon the byte or frame with no pulses; after release, reception SHALL restart at the next start bit.

Structure
REQ-032 A shared package uart_pkg SHALL hold:
- The bit-FSM and frame-FSM state enums.
- FRAME_HDR=8'hA5 and PAYLOAD_BYTES=4.
REQ-033 The byte receiver (REQ-014..020) SHALL be a sub-module uart_rx_byte.
- uart_frame_rx SHALL instantiate it and implement the frame FSM.

Verification (CLKS_PER_BIT=16)
REQ-034 Send byte 8'h3C -> byte_valid pulses once, rx_data=8'h3C, and no flags are set.
REQ-035 Send A5 11 22 33 44 00 (XOR of the payload is 8'h44, so the check byte 8'h00 mismatches) -> chk_err=1 and rx_word stays 0; then send A5 11 22 33 44 44 -> word_valid pulses once and rx_word=32'h44332211.
REQ-036 Send a 4-cycle low glitch on an idle line -> no byte_valid and no flags; a following byte 8'h5A is received correctly.
REQ-037 Send byte 8'hFF with the stop bit low for 3 bit-times -> frame_err=1, no byte_valid, and the next byte 8'h01 is received; then pulse clr_err -> frame_err=0.
REQ-038 Send A5 11 22, then assert rst_n low during the 4th byte -> all outputs are 0; after release, a full good frame A5 01 02 03 04 04 gives rx_word=32'h04030201.
REQ-039 Send a framing error during payload byte 2, then a good frame A5 AA BB CC DD 00 -> rx_word=32'hDDCCBBAA with one word_valid.
